// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment bus receiver.
// Glyph patterns are gfedcba with bit0 = segment A.
package sevenseg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] one_hot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Unrecognised patterns report ok = 0 and nibble = 0.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [3:0] nibble
);

    always_comb begin
        ok     = 1'b1;
        nibble = 4'h0;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_mux_receiver.sv
// Receives a time-multiplexed 7-segment bus, qualifies each digit by stability,
// decodes it and publishes a coherent 4-digit frame once all slots are written.
module sevenseg_mux_receiver
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT        = 65535,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  en,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  glyph_ok,
    output logic        frame_valid,
    output logic        multi_en_err,
    output logic        stalled
);

    localparam logic [7:0]  SEG_POL     = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]  EN_POL      = EN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES);
    localparam logic [19:0] TIMEOUT_V   = 20'(TIMEOUT);

    logic [7:0]  seg_q, seg_p;
    logic [3:0]  en_q, en_p;
    state_t      state, state_next;
    logic [7:0]  count, count_next;
    logic        write;
    logic [3:0]  mask;
    logic [3:0]  slot_nib [4];
    logic [3:0]  slot_dp;
    logic [3:0]  slot_ok;
    logic [19:0] stall_cnt;

    logic        dec_ok;
    logic [3:0]  dec_nib;
    logic        same, one_hot, multi_hot, frame_done;
    logic [1:0]  idx;

    sevenseg_glyph_decode u_decode (
        .pattern (seg_q[6:0]),
        .ok      (dec_ok),
        .nibble  (dec_nib)
    );

    assign same       = (seg_q == seg_p) && (en_q == en_p);
    assign one_hot    = is_one_hot(en_q);
    assign multi_hot  = !one_hot && (en_q != 4'd0);
    assign idx        = one_hot_index(en_q);
    assign frame_done = write && ((mask | en_q) == 4'hF);
    assign stalled    = (stall_cnt == TIMEOUT_V);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        write      = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_next = TRACK;
                    count_next = 8'd1;
                end
            end
            TRACK: begin
                if (same) begin
                    count_next = count + 8'd1;
                    if (count_next == STABLE_LAST) begin
                        write      = 1'b1;
                        state_next = HELD;
                    end
                end else if (one_hot) begin
                    count_next = 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            HELD: begin
                if (!same) begin
                    if (one_hot) begin
                        state_next = TRACK;
                        count_next = 8'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= 8'd0;
            en_q         <= 4'd0;
            seg_p        <= 8'd0;
            en_p         <= 4'd0;
            state        <= IDLE;
            count        <= 8'd0;
            mask         <= 4'd0;
            slot_dp      <= 4'd0;
            slot_ok      <= 4'd0;
            digits       <= 16'd0;
            dp_out       <= 4'd0;
            glyph_ok     <= 4'd0;
            frame_valid  <= 1'b0;
            multi_en_err <= 1'b0;
            stall_cnt    <= 20'd0;
            for (int i = 0; i < 4; i++) slot_nib[i] <= 4'd0;
        end else begin
            seg_q        <= seg ^ SEG_POL;
            en_q         <= en ^ EN_POL;
            seg_p        <= seg_q;
            en_p         <= en_q;
            state        <= state_next;
            count        <= count_next;
            frame_valid  <= frame_done;
            multi_en_err <= multi_en_err | multi_hot;

            if (write) stall_cnt <= 20'd0;
            else if (stall_cnt != TIMEOUT_V) stall_cnt <= stall_cnt + 20'd1;

            if (write) begin
                slot_nib[idx] <= dec_nib;
                slot_dp[idx]  <= seg_q[SEG_DP];
                slot_ok[idx]  <= dec_ok;
                mask          <= frame_done ? 4'd0 : (mask | en_q);
            end

            // The slot written on this edge is forwarded directly into the frame.
            if (frame_done) begin
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == idx) begin
                        digits[4*i +: 4] <= dec_nib;
                        dp_out[i]        <= seg_q[SEG_DP];
                        glyph_ok[i]      <= dec_ok;
                    end else begin
                        digits[4*i +: 4] <= slot_nib[i];
                        dp_out[i]        <= slot_dp[i];
                        glyph_ok[i]      <= slot_ok[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_mux_receiver.sv
// Scoreboard bench: two receivers (active-high bus and inverted bus with a short
// timeout); expected frames are queued by stimulus and popped by a monitor.
module tb_sevenseg_mux_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  en_a, en_b;
    logic [15:0] digits_a, digits_b;
    logic [3:0]  dp_a, dp_b, ok_a, ok_b;
    logic        fv_a, fv_b, err_a, err_b, stalled_a, stalled_b;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  ok;
    } frame_t;

    frame_t exp_a[$];
    frame_t exp_b[$];
    int     frames_a = 0;
    int     frames_b = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    sevenseg_mux_receiver #(
        .STABLE_CYCLES(4), .TIMEOUT(65535), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .seg(seg_a), .en(en_a),
        .digits(digits_a), .dp_out(dp_a), .glyph_ok(ok_a),
        .frame_valid(fv_a), .multi_en_err(err_a), .stalled(stalled_a)
    );

    sevenseg_mux_receiver #(
        .STABLE_CYCLES(4), .TIMEOUT(16), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .seg(seg_b), .en(en_b),
        .digits(digits_b), .dp_out(dp_b), .glyph_ok(ok_b),
        .frame_valid(fv_b), .multi_en_err(err_b), .stalled(stalled_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fv_a === 1'b1) begin
            frame_t f;
            frames_a++;
            check("a_frame_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                f = exp_a.pop_front();
                check("a_digits", 32'(digits_a), 32'(f.d));
                check("a_dp_out", 32'(dp_a), 32'(f.dp));
                check("a_glyph_ok", 32'(ok_a), 32'(f.ok));
            end
        end
        if (fv_b === 1'b1) begin
            frame_t f;
            frames_b++;
            check("b_frame_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                f = exp_b.pop_front();
                check("b_digits", 32'(digits_b), 32'(f.d));
                check("b_dp_out", 32'(dp_b), 32'(f.dp));
                check("b_glyph_ok", 32'(ok_b), 32'(f.ok));
            end
        end
    end

    task automatic drive_a(input logic [7:0] s, input logic [3:0] e, input int n);
        repeat (n) begin
            @(negedge clk);
            seg_a = s;
            en_a  = e;
        end
    endtask

    task automatic drive_b(input logic [7:0] s, input logic [3:0] e, input int n);
        repeat (n) begin
            @(negedge clk);
            seg_b = s;
            en_b  = e;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst   = 1'b1;
        seg_a = 8'h00;
        en_a  = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, "_digits"}, 32'(digits_a), 32'h0);
        check({tag, "_dp"}, 32'(dp_a), 32'h0);
        check({tag, "_ok"}, 32'(ok_a), 32'h0);
        check({tag, "_fv"}, 32'(fv_a), 32'h0);
        check({tag, "_err"}, 32'(err_a), 32'h0);
        check({tag, "_stalled"}, 32'(stalled_a), 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        seg_a = 8'h00;
        en_a  = 4'h0;
        seg_b = 8'hFF;
        en_b  = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_a_cleared("reset");
        check("reset_b_stalled", 32'(stalled_b), 32'h0);

        // Full frame "4321".
        exp_a.push_back('{d: 16'h4321, dp: 4'h0, ok: 4'hF});
        drive_a(8'h06, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h4F, 4'b0100, 6);
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 4);
        check("t1_frames", 32'(frames_a), 32'd1);
        check("t1_digits_hold", 32'(digits_a), 32'h4321);

        // Digit 2 held one cycle short: no frame; second pass rewrites digit 0 to 5
        // and the frame completes on the digit 2 write.
        drive_a(8'h06, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h4F, 4'b0100, 3);
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 3);
        check("t2_no_frame_short", 32'(frames_a), 32'd1);
        exp_a.push_back('{d: 16'h4325, dp: 4'h0, ok: 4'hF});
        drive_a(8'h6D, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h4F, 4'b0100, 6);
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 4);
        check("t2_frames", 32'(frames_a), 32'd2);

        pulse_reset();
        check_a_cleared("rst1");

        // One-cycle multi-hot enable mid-frame.
        exp_a.push_back('{d: 16'h4321, dp: 4'h0, ok: 4'hF});
        drive_a(8'h06, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h5B, 4'b0101, 1);
        drive_a(8'h4F, 4'b0100, 6);
        check("t3_err_set", 32'(err_a), 32'h1);
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 4);
        check("t3_frames", 32'(frames_a), 32'd3);
        check("t3_err_sticky", 32'(err_a), 32'h1);
        pulse_reset();
        check("t3_err_cleared", 32'(err_a), 32'h0);

        // Illegal glyph 0x49 with dp on digit 0.
        exp_a.push_back('{d: 16'h4320, dp: 4'b0001, ok: 4'b1110});
        drive_a(8'hC9, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h4F, 4'b0100, 6);
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 4);
        check("t4_frames", 32'(frames_a), 32'd4);

        // Inverted bus "F0A8", then idle until the stall timeout.
        exp_b.push_back('{d: 16'hF0A8, dp: 4'h0, ok: 4'hF});
        drive_b(~8'h7F, ~4'b0001, 6);
        drive_b(~8'h77, ~4'b0010, 6);
        drive_b(~8'h3F, ~4'b0100, 6);
        drive_b(~8'h71, ~4'b1000, 6);
        drive_b(8'hFF, 4'hF, 6);
        check("t5_frames", 32'(frames_b), 32'd1);
        check("t5_not_yet_stalled", 32'(stalled_b), 32'h0);
        drive_b(8'hFF, 4'hF, 14);
        check("t5_stalled", 32'(stalled_b), 32'h1);
        drive_b(~8'h06, ~4'b0001, 6);
        check("t5_stall_cleared", 32'(stalled_b), 32'h0);
        drive_b(8'hFF, 4'hF, 2);

        // Reset between the 3rd and 4th digits discards the frame.
        drive_a(8'h06, 4'b0001, 6);
        drive_a(8'h5B, 4'b0010, 6);
        drive_a(8'h4F, 4'b0100, 6);
        pulse_reset();
        check_a_cleared("t6_rst");
        drive_a(8'h66, 4'b1000, 6);
        drive_a(8'h00, 4'b0000, 4);
        check("t6_no_frame", 32'(frames_a), 32'd4);
        check("t6_digits_zero", 32'(digits_a), 32'h0);

        repeat (2) @(negedge clk);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_mux_receiver.md
# sevenseg_mux_receiver

Receiving end of the multiplexed 7-segment display bus driven by the calculator top (segment byte plus four digit enables). Samples the time-multiplexed segment/enable pair, qualifies each digit by stability, decodes the glyph back to a hex nibble and publishes a coherent 4-digit frame. Used as an on-chip loopback checker and as the front end of a display-snooping test harness.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (range 2..255).
- TIMEOUT, 65535: cycles without an accepted digit before `stalled` asserts (range 16..2^20-1).
- SEG_ACTIVE_LOW, 0: 1 = segment bits are active-low on the bus.
- EN_ACTIVE_LOW, 0: 1 = digit enables are active-low on the bus.

Ports:
- clk  in  1  single clock; every register is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- seg  in  8  segment bus, bit0=A … bit6=G, bit7=dp.
- en  in  4  digit enables, bit0 = rightmost digit.
- digits  out  16  published hex nibbles, digit i in [4i+3:4i]; reset 0.
- dp_out  out  4  published decimal points; reset 0.
- glyph_ok  out  4  1 = digit i decoded to a legal glyph; reset 0.
- frame_valid  out  1  one-cycle pulse when a new frame is published; reset 0.
- multi_en_err  out  1  sticky: more than one enable seen active; reset 0.
- stalled  out  1  no digit accepted for TIMEOUT cycles; reset 0.

## Operation
- Input stage: `seg`/`en` registered once, normalised to active-high per parameters.
- Glyph decode (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Any other pattern: nibble 0, glyph_ok 0. dp passes through independently.
- FSM on the registered sample:
  - IDLE: enable not one-hot. One-hot sample -> TRACK, count=1.
  - TRACK: sample identical to previous -> count+1; differs -> count=1 (stay TRACK if one-hot, else IDLE). count reaching STABLE_CYCLES -> write slot, set mask bit, -> HELD.
  - HELD: identical sample -> stay, no rewrite. Any change -> TRACK (count=1) or IDLE.
- Slot rewrite before frame completes: overwrite value, mask unchanged.
- Frame: when the write makes mask == 1111, publish all four slots (including the one written this edge, by bypass) to `digits`/`dp_out`/`glyph_ok`, pulse `frame_valid`, clear mask to 0000 on the same edge.
- Enable all-zero (blanking) -> IDLE, no error.
- Multi-hot enable -> IDLE and set `multi_en_err`; cleared only by rst.
- Stall counter: increments each cycle, saturates at TIMEOUT, zeroed on every slot write. `stalled` = counter == TIMEOUT; deasserts on the edge of the next slot write.

## Timing
- Pattern stable on the pins for cycles c .. c+STABLE_CYCLES-1: slot written at the edge ending cycle c+STABLE_CYCLES; published outputs visible in cycle c+STABLE_CYCLES+1 if it completed a frame.
- Stability shorter than STABLE_CYCLES: no write, no partial state kept.
- `frame_valid` high exactly one cycle; published outputs hold until the next frame.
- rst mid-operation: all outputs, slots, mask, counters and FSM (IDLE) cleared on that edge; frame in progress discarded.

## Structure
- Package `sevenseg_pkg`: glyph constants GLYPH_0..GLYPH_F, segment bit indices (SEG_A..SEG_DP), FSM state typedef (IDLE/TRACK/HELD).
- Sub-module `sevenseg_glyph_decode`: combinational 7-bit pattern -> {ok, nibble}; instantiated once on the registered sample.
- Top holds input register, FSM, stability counter, slot/mask registers, stall counter.

## Test plan
- Present 0x06/en=0001, 0x5B/0010, 0x4F/0100, 0x66/1000, each 6 cycles (STABLE_CYCLES=4) -> one `frame_valid`, digits=0x4321, glyph_ok=1111, dp_out=0000.
- Same sequence but digit 2 held only 3 cycles, then loop again with full length -> no frame on first pass, exactly one frame after second pass.
- en=0101 for one cycle mid-frame -> `multi_en_err` stays 1 until rst; subsequent full frame still published correctly.
- Digit 0 pattern 0x49 (illegal) with dp set, others legal -> glyph_ok=1110, digits[3:0]=0, dp_out=0001.
- SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, inverted bus for "F0A8" -> digits=0xF0A8; then freeze en=1111(inactive) for TIMEOUT cycles -> `stalled`=1, clears on next accepted digit.
- Assert rst between 3rd and 4th digit -> all outputs 0, no `frame_valid` after 4th digit alone.
